// File: rtl/serial_sub_pkg.sv
// Shared types and constants for the bit-serial subtractor.
// The optional overflow output is enabled with the SERIAL_SUB_OVERFLOW_EN macro.
package serial_sub_pkg;

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    SHIFT = 2'd1,
    DONE  = 2'd2
  } state_t;

  localparam int WIDTH_DEFAULT = 4;

  // Never narrower than one bit, so a 2-bit subtractor still has a usable counter.
  function automatic int cnt_width(input int w);
    return (w < 2) ? 1 : $clog2(w);
  endfunction

  localparam int CNT_W_DEFAULT = cnt_width(WIDTH_DEFAULT);

endpackage

// File: rtl/full_subtractor.sv
// One-bit full subtractor: difference and borrow-out of a - b - bin.
module full_subtractor (
  input  logic a,
  input  logic b,
  input  logic bin,
  output logic d,
  output logic bout
);

  assign d    = a ^ b ^ bin;
  assign bout = (~a & b) | (~a & bin) | (b & bin);

endmodule

// File: rtl/serial_subtractor.sv
// Bit-serial subtractor computing A - B - BIN one bit per clock, LSB first.
// Define SERIAL_SUB_OVERFLOW_EN to add the registered two's-complement overflow output V.
module serial_subtractor
  import serial_sub_pkg::*;
#(
  parameter int WIDTH = WIDTH_DEFAULT
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             start,
  input  logic [WIDTH-1:0] A,
  input  logic [WIDTH-1:0] B,
  input  logic             BIN,
  output logic [WIDTH-1:0] D,
  output logic             BOUT,
  output logic             busy,
  output logic             done
`ifdef SERIAL_SUB_OVERFLOW_EN
  ,
  output logic             V
`endif
);

  localparam int             CntW    = cnt_width(WIDTH);
  localparam logic [CntW-1:0] LastCnt = CntW'(WIDTH - 1);

  state_t            state_q, state_d;
  logic [WIDTH-1:0]  a_q, a_d;
  logic [WIDTH-1:0]  b_q, b_d;
  logic              br_q, br_d;
  logic [CntW-1:0]   cnt_q, cnt_d;
  logic [WIDTH-1:0]  diff_q, diff_d;
  logic              bout_q, bout_d;
`ifdef SERIAL_SUB_OVERFLOW_EN
  logic              v_q, v_d;
`endif

  logic fsBit;
  logic fsBorrow;

  full_subtractor u_fs (
    .a    (a_q[0]),
    .b    (b_q[0]),
    .bin  (br_q),
    .d    (fsBit),
    .bout (fsBorrow)
  );

  // Operands shift right so bit 0 always feeds the subtractor; results enter at the MSB.
  always_comb begin
    state_d = state_q;
    a_d     = a_q;
    b_d     = b_q;
    br_d    = br_q;
    cnt_d   = cnt_q;
    diff_d  = diff_q;
    bout_d  = bout_q;
`ifdef SERIAL_SUB_OVERFLOW_EN
    v_d     = v_q;
`endif
    case (state_q)
      IDLE: begin
        if (start) begin
          a_d     = A;
          b_d     = B;
          br_d    = BIN;
          cnt_d   = '0;
          state_d = SHIFT;
        end
      end
      SHIFT: begin
        a_d    = a_q >> 1;
        b_d    = b_q >> 1;
        br_d   = fsBorrow;
        diff_d = {fsBit, diff_q[WIDTH-1:1]};
        if (cnt_q == LastCnt) begin
          // On the MSB step br_q is the borrow into the MSB, fsBorrow the borrow out.
          bout_d  = fsBorrow;
`ifdef SERIAL_SUB_OVERFLOW_EN
          v_d     = br_q ^ fsBorrow;
`endif
          state_d = DONE;
        end else begin
          cnt_d = cnt_q + 1'b1;
        end
      end
      DONE: begin
        state_d = IDLE;
      end
      default: begin
        state_d = IDLE;
      end
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q <= IDLE;
      a_q     <= '0;
      b_q     <= '0;
      br_q    <= 1'b0;
      cnt_q   <= '0;
      diff_q  <= '0;
      bout_q  <= 1'b0;
`ifdef SERIAL_SUB_OVERFLOW_EN
      v_q     <= 1'b0;
`endif
    end else begin
      state_q <= state_d;
      a_q     <= a_d;
      b_q     <= b_d;
      br_q    <= br_d;
      cnt_q   <= cnt_d;
      diff_q  <= diff_d;
      bout_q  <= bout_d;
`ifdef SERIAL_SUB_OVERFLOW_EN
      v_q     <= v_d;
`endif
    end
  end

  assign D    = diff_q;
  assign BOUT = bout_q;
  assign busy = (state_q == SHIFT);
  assign done = (state_q == DONE);
`ifdef SERIAL_SUB_OVERFLOW_EN
  assign V    = v_q;
`endif

endmodule

// File: tb/tb_serial_subtractor.sv
// Directed testbench for serial_subtractor (4-bit); exercises V when SERIAL_SUB_OVERFLOW_EN is defined.
module tb_serial_subtractor;

  logic       clk;
  logic       rst;
  logic       start;
  logic [3:0] A;
  logic [3:0] B;
  logic       BIN;
  logic [3:0] D;
  logic       BOUT;
  logic       busy;
  logic       done;
`ifdef SERIAL_SUB_OVERFLOW_EN
  logic       V;
`endif

  int checks;
  int errors;
  int doneCnt;

  serial_subtractor #(.WIDTH(4)) dut (
    .clk   (clk),
    .rst   (rst),
    .start (start),
    .A     (A),
    .B     (B),
    .BIN   (BIN),
    .D     (D),
    .BOUT  (BOUT),
    .busy  (busy),
    .done  (done)
`ifdef SERIAL_SUB_OVERFLOW_EN
    ,
    .V     (V)
`endif
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Counts every cycle in which done is seen high, sampled mid-cycle.
  always @(negedge clk) begin
    if (done === 1'b1) doneCnt++;
  end

  // Starts an operation from the current negedge (block must be IDLE) and returns
  // the number of negedges until done is seen, or -1 if it never appears.
  task automatic doOp(input logic [3:0] a, input logic [3:0] b, input logic bin, output int lat);
    A     = a;
    B     = b;
    BIN   = bin;
    start = 1'b1;
    lat   = -1;
    for (int n = 1; n <= 20; n++) begin
      @(negedge clk);
      start = 1'b0;
      if (done === 1'b1) begin
        lat = n;
        break;
      end
    end
  endtask

  task automatic test_reset();
    rst   = 1'b1;
    start = 1'b0;
    A     = 4'hF;
    B     = 4'hF;
    BIN   = 1'b1;
    repeat (2) @(negedge clk);
    checks++; if (D !== 4'h0) begin errors++; $display("[TB] FAIL reset_D got %b want 0000", D); end
    checks++; if (BOUT !== 1'b0) begin errors++; $display("[TB] FAIL reset_BOUT got %b want 0", BOUT); end
    checks++; if (busy !== 1'b0) begin errors++; $display("[TB] FAIL reset_busy got %b want 0", busy); end
    checks++; if (done !== 1'b0) begin errors++; $display("[TB] FAIL reset_done got %b want 0", done); end
`ifdef SERIAL_SUB_OVERFLOW_EN
    checks++; if (V !== 1'b0) begin errors++; $display("[TB] FAIL reset_V got %b want 0", V); end
`endif
    rst = 1'b0;
    @(negedge clk);
  endtask

  task automatic test_basic();
    int lat;
    A     = 4'd1;
    B     = 4'd3;
    BIN   = 1'b0;
    start = 1'b1;
    @(negedge clk);
    start = 1'b0;
    checks++; if (busy !== 1'b1) begin errors++; $display("[TB] FAIL basic_busy got %b want 1", busy); end
    lat = 1;
    for (int n = 2; n <= 20; n++) begin
      @(negedge clk);
      if (done === 1'b1) begin
        lat = n;
        break;
      end
    end
    checks++; if (lat !== 5) begin errors++; $display("[TB] FAIL basic_latency got %0d want 5", lat); end
    checks++; if (D !== 4'b1110) begin errors++; $display("[TB] FAIL basic_D got %b want 1110", D); end
    checks++; if (BOUT !== 1'b1) begin errors++; $display("[TB] FAIL basic_BOUT got %b want 1", BOUT); end
    @(negedge clk);
    checks++; if (done !== 1'b0) begin errors++; $display("[TB] FAIL basic_done_width got %b want 0", done); end
    repeat (3) @(negedge clk);
    checks++; if (D !== 4'b1110) begin errors++; $display("[TB] FAIL basic_hold_D got %b want 1110", D); end
    checks++; if (BOUT !== 1'b1) begin errors++; $display("[TB] FAIL basic_hold_BOUT got %b want 1", BOUT); end
  endtask

  typedef struct {
    logic [3:0] a;
    logic [3:0] b;
    logic       bin;
    logic [3:0] d;
    logic       bo;
  } vec_t;

  task automatic test_vectors();
    vec_t vecs[5];
    int   lat;
    vecs[0] = '{4'd11, 4'd9,  1'b0, 4'b0010, 1'b0};
    vecs[1] = '{4'd7,  4'd13, 1'b0, 4'b1010, 1'b1};
    vecs[2] = '{4'd15, 4'd1,  1'b0, 4'b1110, 1'b0};
    vecs[3] = '{4'd0,  4'd0,  1'b1, 4'b1111, 1'b1};
    vecs[4] = '{4'd6,  4'd6,  1'b0, 4'b0000, 1'b0};
    for (int i = 0; i < 5; i++) begin
      doOp(vecs[i].a, vecs[i].b, vecs[i].bin, lat);
      checks++; if (D !== vecs[i].d) begin errors++; $display("[TB] FAIL vec%0d_D got %b want %b", i, D, vecs[i].d); end
      checks++; if (BOUT !== vecs[i].bo) begin errors++; $display("[TB] FAIL vec%0d_BOUT got %b want %b", i, BOUT, vecs[i].bo); end
      @(negedge clk);
    end
  endtask

  task automatic test_ignore_start();
    int startDone;
    startDone = doneCnt;
    A     = 4'd5;
    B     = 4'd2;
    BIN   = 1'b0;
    start = 1'b1;
    @(negedge clk);
    start = 1'b0;
    @(negedge clk);
    // Mid-SHIFT: new operands and a start pulse that must be ignored.
    A     = 4'd9;
    B     = 4'd12;
    BIN   = 1'b1;
    start = 1'b1;
    @(negedge clk);
    start = 1'b0;
    repeat (2) @(negedge clk);
    checks++; if (done !== 1'b1) begin errors++; $display("[TB] FAIL ignore_done_timing got %b want 1", done); end
    // Start raised while in DONE must not be queued either.
    start = 1'b1;
    @(negedge clk);
    start = 1'b0;
    checks++; if (D !== 4'd3) begin errors++; $display("[TB] FAIL ignore_D got %b want 0011", D); end
    checks++; if (BOUT !== 1'b0) begin errors++; $display("[TB] FAIL ignore_BOUT got %b want 0", BOUT); end
    @(negedge clk);
    checks++; if (busy !== 1'b0) begin errors++; $display("[TB] FAIL ignore_busy got %b want 0", busy); end
    repeat (8) @(negedge clk);
    checks++; if (doneCnt - startDone !== 1) begin errors++; $display("[TB] FAIL ignore_done_count got %0d want 1", doneCnt - startDone); end
  endtask

  task automatic test_rst_abort();
    int startDone;
    int lat;
    startDone = doneCnt;
    A     = 4'd3;
    B     = 4'd5;
    BIN   = 1'b0;
    start = 1'b1;
    @(negedge clk);
    start = 1'b0;
    @(negedge clk);
    rst = 1'b1;
    @(negedge clk);
    checks++; if (D !== 4'h0) begin errors++; $display("[TB] FAIL abort_D got %b want 0000", D); end
    checks++; if (BOUT !== 1'b0) begin errors++; $display("[TB] FAIL abort_BOUT got %b want 0", BOUT); end
    checks++; if (busy !== 1'b0) begin errors++; $display("[TB] FAIL abort_busy got %b want 0", busy); end
    rst = 1'b0;
    repeat (8) @(negedge clk);
    checks++; if (doneCnt - startDone !== 0) begin errors++; $display("[TB] FAIL abort_done_count got %0d want 0", doneCnt - startDone); end
    doOp(4'd12, 4'd5, 1'b0, lat);
    checks++; if (lat !== 5) begin errors++; $display("[TB] FAIL abort_restart_latency got %0d want 5", lat); end
    checks++; if (D !== 4'd7) begin errors++; $display("[TB] FAIL abort_restart_D got %b want 0111", D); end
    checks++; if (BOUT !== 1'b0) begin errors++; $display("[TB] FAIL abort_restart_BOUT got %b want 0", BOUT); end
    @(negedge clk);
  endtask

  task automatic test_back_to_back();
    int lat;
    doOp(4'd2, 4'd1, 1'b0, lat);
    checks++; if (D !== 4'd1) begin errors++; $display("[TB] FAIL b2b_first_D got %b want 0001", D); end
    @(negedge clk);
    doOp(4'd4, 4'd9, 1'b1, lat);
    checks++; if (lat !== 5) begin errors++; $display("[TB] FAIL b2b_second_latency got %0d want 5", lat); end
    checks++; if (D !== 4'b1010) begin errors++; $display("[TB] FAIL b2b_second_D got %b want 1010", D); end
    checks++; if (BOUT !== 1'b1) begin errors++; $display("[TB] FAIL b2b_second_BOUT got %b want 1", BOUT); end
    @(negedge clk);
  endtask

`ifdef SERIAL_SUB_OVERFLOW_EN
  task automatic test_overflow();
    int lat;
    doOp(4'b0111, 4'b1000, 1'b0, lat);
    checks++; if (D !== 4'b1111) begin errors++; $display("[TB] FAIL ovf_D got %b want 1111", D); end
    checks++; if (BOUT !== 1'b1) begin errors++; $display("[TB] FAIL ovf_BOUT got %b want 1", BOUT); end
    checks++; if (V !== 1'b1) begin errors++; $display("[TB] FAIL ovf_V got %b want 1", V); end
    repeat (3) @(negedge clk);
    checks++; if (V !== 1'b1) begin errors++; $display("[TB] FAIL ovf_hold_V got %b want 1", V); end
    doOp(4'd11, 4'd9, 1'b0, lat);
    checks++; if (V !== 1'b0) begin errors++; $display("[TB] FAIL noovf_V got %b want 0", V); end
    @(negedge clk);
  endtask
`endif

  initial begin
    checks  = 0;
    errors  = 0;
    doneCnt = 0;
    rst     = 1'b1;
    start   = 1'b0;
    A       = '0;
    B       = '0;
    BIN     = 1'b0;
    @(negedge clk);
    test_reset();
    test_basic();
    test_vectors();
    test_ignore_start();
    test_rst_abort();
    test_back_to_back();
`ifdef SERIAL_SUB_OVERFLOW_EN
    test_overflow();
`endif
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

  initial begin
    #100000;
    $display("[TB] FAIL watchdog got timeout want completion");
    $fatal(1, "[TB] watchdog expired");
  end

endmodule

// File: doc/serial_subtractor.md
SERIAL_SUBTRACTOR -- requirements
Module: serial_subtractor

Interface
REQ-001 Parameter WIDTH, default 4: operand and difference width in bits, legal range 2..16.
REQ-002 Port clk, input, 1 bit: the only clock; all state updates on the rising edge.
REQ-003 Port rst, input, 1 bit: reset, synchronous and active-high.
REQ-004 Port start, input, 1 bit: request to begin a subtraction; sampled only in IDLE.
REQ-005 Port A, input, WIDTH bits: minuend, captured on an accepted start.
REQ-006 Port B, input, WIDTH bits: subtrahend, captured on an accepted start.
REQ-007 Port BIN, input, 1 bit: borrow-in, captured on an accepted start.
REQ-008 Port D, output, WIDTH bits: difference A-B-BIN modulo 2^WIDTH, registered.
REQ-009 Port BOUT, output, 1 bit: borrow-out, 1 when A < B+BIN unsigned, registered.
REQ-010 Port busy, output, 1 bit: high while in SHIFT.
REQ-011 Port done, output, 1 bit: single-cycle pulse, high while in DONE.

Function
REQ-012 Three states SHALL exist: IDLE, SHIFT and DONE.
REQ-013 In IDLE with start=1, the block SHALL capture A, B and BIN into internal shift and borrow registers, clear the bit counter, and go to SHIFT; otherwise it SHALL stay in IDLE.
REQ-014 Each SHIFT cycle SHALL produce one difference bit, LSB first: d = a^b^br; br_next = (~a&b) | (~a&br) | (b&br).
REQ-015 Each SHIFT cycle SHALL shift the result bit into the difference register from the MSB side.
REQ-016 SHIFT SHALL last exactly WIDTH cycles; the counter runs 0..WIDTH-1, then the block goes to DONE.
REQ-017 In DONE, D and BOUT SHALL be final and done=1 for exactly one cycle; the next state SHALL be IDLE unconditionally.
REQ-018 Latency SHALL be WIDTH+1 cycles from the accepting edge to the done pulse (4-bit: done in cycle 5).
REQ-019 D and BOUT SHALL hold their final values through IDLE until the next accepted start.
REQ-020 On the next accepted start, D and BOUT SHALL become don't-care until the following done.
REQ-021 start in SHIFT or DONE SHALL be ignored and SHALL NOT be queued.
REQ-022 Back-to-back operation: start asserted in the first IDLE cycle after DONE SHALL be accepted, giving a WIDTH+2-cycle throughput period.
REQ-023 Changes on A, B or BIN after capture SHALL NOT affect the result in progress.
REQ-024 A=B with BIN=0 SHALL give D=0 and BOUT=0.
REQ-025 A=0, B=0, BIN=1 SHALL wrap to D=all-ones with BOUT=1.

Reset
REQ-026 rst=1 SHALL force state IDLE and clear D, BOUT, busy, done, the counter and all internal registers to 0 on the next edge.
REQ-027 rst SHALL take priority over start and over any operation in progress; an interrupted operation SHALL be aborted with no done pulse.
REQ-028 The first start after rst deasserts SHALL be accepted normally.

Configuration
REQ-029 With macro SERIAL_SUB_OVERFLOW_EN defined, the block SHALL add output V (1 bit, registered) giving two's-complement overflow of A-B-BIN, computed as the borrow into the MSB XOR BOUT.
REQ-030 V SHALL obey the same valid, hold and reset rules as BOUT.
REQ-031 Without SERIAL_SUB_OVERFLOW_EN, port V and its logic SHALL be absent and all other behaviour SHALL be identical.

Structure
REQ-032 Package serial_sub_pkg SHALL hold the state typedef (IDLE/SHIFT/DONE), the default WIDTH constant and the counter-width constant, computed as clog2(WIDTH).
REQ-033 A single 1-bit combinational sub-module full_subtractor (inputs a, b, bin; outputs d, bout) SHALL implement REQ-014 and be instantiated once.

Verification
REQ-034 A=1, B=3, BIN=0 -> D=1110, BOUT=1, done in cycle 5 after start.
REQ-035 Two cases: A=11, B=9, BIN=0 -> D=0010, BOUT=0; A=7, B=13, BIN=0 -> D=1010, BOUT=1.
REQ-036 Two cases: A=15, B=1, BIN=0 -> D=1110, BOUT=0; A=0, B=0, BIN=1 -> D=1111, BOUT=1.
REQ-037 Start re-pulsed during SHIFT with new operands -> ignored, first result unchanged, exactly one done pulse.
REQ-038 rst asserted in SHIFT cycle 2 -> all outputs 0, no done pulse; a new start then completes correctly.
REQ-039 With SERIAL_SUB_OVERFLOW_EN: A=0111, B=1000, BIN=0 -> D=1111, BOUT=1, V=1; A=11, B=9 -> V=0.
